// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared funct3, cache write-width and state encodings
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WW_NONE = 2'd0;
    localparam logic [1:0] WW_BYTE = 2'd1;
    localparam logic [1:0] WW_HALF = 2'd2;
    localparam logic [1:0] WW_WORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2
    } lsu_state_t;

    // Unsigned variants exist only for loads; anything off its natural alignment faults.
    function automatic logic access_fault(input logic store, input logic [2:0] funct3,
                                          input logic [1:0] off);
        logic f;
        case (funct3)
            F3_B:    f = 1'b0;
            F3_BU:   f = store;
            F3_H:    f = off[0];
            F3_HU:   f = store | off[0];
            F3_W:    f = (off != 2'd0);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational load extract/extend and store byte/half merge
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [31:0] shifted;
    assign shifted = word >> {off, 3'b000};

    always_comb begin
        load_data = '0;
        merged    = word;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'b0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'b0, shifted[15:0]};
            F3_W:    load_data = word;
            default: load_data = '0;
        endcase
        case (funct3[1:0])
            2'b00:   merged[{off, 3'b000} +: 8]        = wdata[7:0];
            2'b01:   merged[{off[1], 4'b0000} +: 16]   = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit with read-modify-write for sub-word stores
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WORD_ADDR_BITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_fault,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_write_data,
    output logic [1:0]  dc_write_width,
    input  logic [31:0] dc_read_data
);

    lsu_state_t state, state_next;

    logic                      lat_store;
    logic [2:0]                lat_funct3;
    logic [WORD_ADDR_BITS+1:0] lat_addr;
    logic [31:0]               lat_wdata;
    logic [4:0]                lat_rd;
    logic [31:0]               merge_word;

    logic        fault, rmw, direct;
    logic [1:0]  off;
    logic [31:0] load_data, merged;

    // Byte-address bits above the cache index are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:WORD_ADDR_BITS+2];

    assign off    = lat_addr[1:0];
    assign fault  = access_fault(lat_store, lat_funct3, off);
    assign rmw    = lat_store && !fault && (off != 2'd0);
    assign direct = lat_store && !fault && (off == 2'd0);

    lsu_align u_align (
        .word      (dc_read_data),
        .off       (off),
        .funct3    (lat_funct3),
        .wdata     (lat_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        dc_addr        = '0;
        dc_write_data  = '0;
        dc_write_width = WW_NONE;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                dc_addr[WORD_ADDR_BITS-1:0] = lat_addr[WORD_ADDR_BITS+1:2];
                if (direct) begin
                    dc_write_data = lat_wdata;
                    case (lat_funct3)
                        F3_B:    dc_write_width = WW_BYTE;
                        F3_H:    dc_write_width = WW_HALF;
                        default: dc_write_width = WW_WORD;
                    endcase
                end
                state_next = rmw ? ST_WRITE : ST_IDLE;
            end
            ST_WRITE: begin
                dc_addr[WORD_ADDR_BITS-1:0] = lat_addr[WORD_ADDR_BITS+1:2];
                dc_write_data  = merge_word;
                dc_write_width = WW_WORD;
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_store  <= 1'b0;
            lat_funct3 <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_rd     <= '0;
            merge_word <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_rd    <= '0;
            resp_fault <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_store  <= req_store;
                        lat_funct3 <= req_funct3;
                        lat_addr   <= req_addr[WORD_ADDR_BITS+1:0];
                        lat_wdata  <= req_wdata;
                        lat_rd     <= req_rd;
                    end
                end
                ST_ACCESS: begin
                    merge_word <= merged;
                    if (!rmw) begin
                        resp_valid <= 1'b1;
                        resp_fault <= fault;
                        resp_rdata <= (lat_store || fault) ? 32'd0 : load_data;
                        resp_rd    <= lat_rd;
                    end
                end
                ST_WRITE: begin
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_rdata <= '0;
                    resp_rd    <= lat_rd;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - vector table, reset-abort sequence and randomized checks against a word-level model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_fault;
    logic [31:0] dc_addr;
    logic [31:0] dc_write_data;
    logic [1:0]  dc_write_width;
    logic [31:0] dc_read_data;

    load_store_unit #(.WORD_ADDR_BITS(20)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_rd        (resp_rd),
        .resp_fault     (resp_fault),
        .dc_addr        (dc_addr),
        .dc_write_data  (dc_write_data),
        .dc_write_width (dc_write_width),
        .dc_read_data   (dc_read_data)
    );

    always #5 clk = ~clk;

    // Cache model: 1024 words indexed by the low word-index bits, plus a backdoor preload port.
    logic [31:0] mem [1024];
    logic [31:0] shadow [1024];
    logic        bd_en = 1'b0;
    logic [9:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;

    assign dc_read_data = mem[dc_addr[9:0]];

    always @(posedge clk) begin
        if (bd_en) mem[bd_idx] <= bd_val;
        else case (dc_write_width)
            2'd1: mem[dc_addr[9:0]][7:0]  <= dc_write_data[7:0];
            2'd2: mem[dc_addr[9:0]][15:0] <= dc_write_data[15:0];
            2'd3: mem[dc_addr[9:0]]       <= dc_write_data;
            default: ;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic backdoor(input logic [31:0] byte_addr, input logic [31:0] val);
        @(negedge clk);
        bd_en = 1'b1; bd_idx = byte_addr[11:2]; bd_val = val;
        @(negedge clk);
        bd_en = 1'b0;
        shadow[byte_addr[11:2]] = val;
    endtask

    // Reference: each access reads/updates a whole word with size/offset arithmetic.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] word,
                                  output logic f, output logic [31:0] rdat,
                                  output logic [31:0] nw, output int lat);
        int size, off;
        longint v, full, mask;
        off = int'(a % 32'd4);
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0) f = 1'b1;
        else f = (st && f3[2]) || ((off % size) != 0);
        if (size == 0) size = 1;
        full = longint'(1) << (8 * size);
        v = (longint'(word) >> (8 * off)) % full;
        if (!f3[2] && size < 4 && v >= full / 2) v = v - full;
        rdat = (f || st) ? 32'd0 : 32'(v);
        mask = (full - 1) << (8 * off);
        nw = (st && !f) ? ((word & ~32'(mask)) | ((wd << (8 * off)) & 32'(mask))) : word;
        lat = (!f && st && off != 0) ? 3 : 2;
    endfunction

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          output int lat, output logic [1:0] ww1, output logic [31:0] a1,
                          output logic f, output logic [31:0] rdat, output logic [4:0] rrd,
                          output int writes, output logic rdy_at_resp);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0;
        ww1 = dc_write_width; a1 = dc_addr; lat = 1;
        writes = (dc_write_width != 2'd0) ? 1 : 0;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
            if (dc_write_width != 2'd0) writes++;
        end
        f = resp_fault; rdat = resp_rdata; rrd = resp_rd; rdy_at_resp = req_ready;
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        pre;
        logic [31:0] pre_val;
        logic        fault;
        logic [31:0] rdata;
        int          lat;
        logic [1:0]  ww1;
    } vec_t;

    vec_t vt[21];

    initial begin
        int lat, writes;
        logic [1:0]  ww1;
        logic [31:0] a1, rdat, exp_rd, nw;
        logic [4:0]  rrd;
        logic        f, ef, rdy;
        int          elat;

        vt[0]  = '{1'b1, 3'b010, 32'h100,      32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 32'h0,        2, 2'd3};
        vt[1]  = '{1'b0, 3'b010, 32'h100,      32'h0,        1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 2, 2'd0};
        vt[2]  = '{1'b1, 3'b000, 32'h104,      32'h000000AA, 1'b1, 32'h11223344, 1'b0, 32'h0,        2, 2'd1};
        vt[3]  = '{1'b0, 3'b010, 32'h104,      32'h0,        1'b0, 32'h0,        1'b0, 32'h112233AA, 2, 2'd0};
        vt[4]  = '{1'b1, 3'b000, 32'h10A,      32'h00000055, 1'b1, 32'h11223344, 1'b0, 32'h0,        3, 2'd0};
        vt[5]  = '{1'b0, 3'b010, 32'h108,      32'h0,        1'b0, 32'h0,        1'b0, 32'h11553344, 2, 2'd0};
        vt[6]  = '{1'b1, 3'b001, 32'h10A,      32'h0000BEEF, 1'b0, 32'h0,        1'b0, 32'h0,        3, 2'd0};
        vt[7]  = '{1'b0, 3'b010, 32'h108,      32'h0,        1'b0, 32'h0,        1'b0, 32'hBEEF3344, 2, 2'd0};
        vt[8]  = '{1'b0, 3'b000, 32'h203,      32'h0,        1'b1, 32'h80FF0000, 1'b0, 32'hFFFFFF80, 2, 2'd0};
        vt[9]  = '{1'b0, 3'b100, 32'h203,      32'h0,        1'b0, 32'h0,        1'b0, 32'h00000080, 2, 2'd0};
        vt[10] = '{1'b0, 3'b001, 32'h202,      32'h0,        1'b0, 32'h0,        1'b0, 32'hFFFF80FF, 2, 2'd0};
        vt[11] = '{1'b0, 3'b101, 32'h202,      32'h0,        1'b0, 32'h0,        1'b0, 32'h000080FF, 2, 2'd0};
        vt[12] = '{1'b0, 3'b010, 32'h102,      32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        2, 2'd0};
        vt[13] = '{1'b1, 3'b001, 32'h103,      32'h00001234, 1'b0, 32'h0,        1'b1, 32'h0,        2, 2'd0};
        vt[14] = '{1'b0, 3'b011, 32'h100,      32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        2, 2'd0};
        vt[15] = '{1'b1, 3'b100, 32'h100,      32'h000000AB, 1'b0, 32'h0,        1'b1, 32'h0,        2, 2'd0};
        vt[16] = '{1'b0, 3'b010, 32'h100,      32'h0,        1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 2, 2'd0};
        vt[17] = '{1'b1, 3'b010, 32'hFFFFFFFC, 32'h12345678, 1'b0, 32'h0,        1'b0, 32'h0,        2, 2'd3};
        vt[18] = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        1'b0, 32'h0,        1'b0, 32'h12345678, 2, 2'd0};
        vt[19] = '{1'b1, 3'b001, 32'h100,      32'h0000CAFE, 1'b0, 32'h0,        1'b0, 32'h0,        2, 2'd2};
        vt[20] = '{1'b0, 3'b010, 32'h100,      32'h0,        1'b0, 32'h0,        1'b0, 32'hDEADCAFE, 2, 2'd0};

        repeat (3) @(negedge clk);
        chk("reset req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("reset resp_fault", {31'b0, resp_fault}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_rd", {27'b0, resp_rd}, 32'd0);
        chk("reset dc_addr", dc_addr, 32'd0);
        chk("reset dc_write_data", dc_write_data, 32'd0);
        chk("reset dc_write_width", {30'b0, dc_write_width}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            logic [9:0] idx;
            logic [4:0] tag;
            idx = vt[i].addr[11:2];
            tag = 5'(i + 1);
            if (vt[i].pre) backdoor(vt[i].addr, vt[i].pre_val);
            model(vt[i].st, vt[i].f3, vt[i].addr, vt[i].wd, shadow[idx], ef, exp_rd, nw, elat);
            do_req(vt[i].st, vt[i].f3, vt[i].addr, vt[i].wd, tag, lat, ww1, a1, f, rdat, rrd, writes, rdy);
            chk($sformatf("vec%0d fault", i), {31'b0, f}, {31'b0, vt[i].fault});
            chk($sformatf("vec%0d rdata", i), rdat, vt[i].rdata);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d first-cycle width", i), {30'b0, ww1}, {30'b0, vt[i].ww1});
            chk($sformatf("vec%0d dc_addr", i), a1, {12'b0, vt[i].addr[21:2]});
            chk($sformatf("vec%0d resp_rd", i), {27'b0, rrd}, {27'b0, tag});
            chk($sformatf("vec%0d writes", i), 32'(writes), (vt[i].st && !vt[i].fault) ? 32'd1 : 32'd0);
            chk($sformatf("vec%0d ready with resp", i), {31'b0, rdy}, 32'd1);
            shadow[idx] = nw;
            chk($sformatf("vec%0d memory", i), mem[idx], shadow[idx]);
        end

        // Reset in the WRITE cycle of an RMW byte store must abort the write.
        backdoor(32'h300, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h301;
        req_wdata = 32'h55; req_rd = 5'd9;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort access width", {30'b0, dc_write_width}, 32'd0);
        @(negedge clk);
        chk("abort write width", {30'b0, dc_write_width}, 32'd3);
        chk("abort write data", dc_write_data, 32'h11225544);
        #1 reset = 1'b1;
        #1;
        chk("abort width during reset", {30'b0, dc_write_width}, 32'd0);
        chk("abort dc_addr during reset", dc_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("abort ready after release", {31'b0, req_ready}, 32'd1);
        chk("abort no resp_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("abort no late resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("abort memory unchanged", mem[10'h0C0], 32'h11223344);

        for (int w = 0; w < 16; w++) backdoor(32'h400 + 32'(w * 4), $urandom);

        for (int n = 0; n < 300; n++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a, wd;
            logic [4:0]  tag;
            logic [9:0]  idx;
            st  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            a   = 32'h400 + 32'($urandom_range(0, 63));
            wd  = $urandom;
            tag = 5'($urandom_range(0, 31));
            idx = a[11:2];
            model(st, f3, a, wd, shadow[idx], ef, exp_rd, nw, elat);
            do_req(st, f3, a, wd, tag, lat, ww1, a1, f, rdat, rrd, writes, rdy);
            chk($sformatf("rand%0d fault", n), {31'b0, f}, {31'b0, ef});
            chk($sformatf("rand%0d rdata", n), rdat, exp_rd);
            chk($sformatf("rand%0d latency", n), 32'(lat), 32'(elat));
            chk($sformatf("rand%0d resp_rd", n), {27'b0, rrd}, {27'b0, tag});
            shadow[idx] = nw;
            chk($sformatf("rand%0d memory", n), mem[idx], shadow[idx]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
